ram_arbiter: RTL and testbench

Two-master arbiter that shares the single-port SoC data RAM between the core data port (m0) and a loader/debug master (m1). Masters can preload or inspect RAM without halting the core.
- Round-robin arbitration, same-cycle grant.
- Tracks the one outstanding read so the response returns to the correct master.
- Supports a bounded lock so one master can perform an atomic read-modify-write.

---
 rtl/soc_bus_pkg.sv | 41 ++++
 rtl/ram_arbiter_if.sv | 11 +
 rtl/ram_arbiter_rr_pick2.sv | 20 ++
 rtl/ram_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_bus_pkg.sv
// Shared bus types for the SoC data-RAM arbiter: request/response bundles,
// arbiter state encoding and the default lock bound.
package soc_bus_pkg;

  // Default number of consecutive locked cycles before a contender may take over
  localparam int unsigned LOCK_MAX_DEF = 8;

  // Arbiter state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;

  // Master -> arbiter request bundle
  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        lock;
  } bus_req_t;

  // Arbiter -> master response bundle
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } bus_rsp_t;

  // Byte enables presented to the RAM: strobes only matter for writes
  function automatic logic [3:0] wr_strobes(input logic we, input logic [3:0] wstrb);
    logic [3:0] stb;
    if (we) begin
      stb = wstrb;
    end else begin
      stb = 4'b0000;
    end
    return stb;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// One master port of the RAM arbiter: request bundle out of the master,
// response bundle back into it.
interface ram_arbiter_if;
  import soc_bus_pkg::*;

  bus_req_t req_pkt;
  bus_rsp_t rsp_pkt;

  modport master (output req_pkt, input rsp_pkt);
  modport slave  (input req_pkt, output rsp_pkt);
endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin chooser: one-hot grant, ties go to the master that was
// not granted last (rr_last holds the index of the last winner).
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic [1:0] gnt
);

  // Pick the single requester, or on a tie the one that did not win last
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of the single-port SoC data RAM. Same-cycle
// round-robin grant, bounded lock for read-modify-write, and routing of the
// single-cycle read response back to the master that issued the read.
module ram_arbiter
  import soc_bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      m0,
  ram_arbiter_if.slave      m1,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [CNT_W-1:0] lock_cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             rr_last_r;
  logic             rr_last_s;
  logic             pend_r;
  logic             resp_sel_r;

  logic [1:0] req_s;
  logic [1:0] lock_s;
  logic [1:0] pick_s;
  logic [1:0] gnt_s;
  logic       sel_s;
  logic       owner_s;
  logic       at_max_s;
  bus_req_t   sel_req_s;
  bus_rsp_t   rsp0_s;
  bus_rsp_t   rsp1_s;
  logic       unused_s;

  assign req_s    = {m1.req_pkt.req,  m0.req_pkt.req};
  assign lock_s   = {m1.req_pkt.lock, m0.req_pkt.lock};
  assign owner_s  = (state_r == ST_LOCK1);
  assign at_max_s = (lock_cnt_r == LOCK_MAX_C);

  rr_pick2 u_pick (
    .req     (req_s),
    .rr_last (rr_last_r),
    .gnt     (pick_s)
  );

  // Grant: round-robin when idle, only the lock owner while locked, nothing in reset
  always_comb begin
    gnt_s = 2'b00;
    if (rst) begin
      gnt_s = 2'b00;
    end else begin
      case (state_r)
        ST_IDLE:  gnt_s = pick_s;
        ST_LOCK0: gnt_s = {1'b0, req_s[0]};
        ST_LOCK1: gnt_s = {req_s[1], 1'b0};
        default:  gnt_s = 2'b00;
      endcase
    end
  end

  // Steer the granted master's request onto the RAM port
  always_comb begin
    sel_s = gnt_s[1];
    if (sel_s) begin
      sel_req_s = m1.req_pkt;
    end else begin
      sel_req_s = m0.req_pkt;
    end
    ram_en    = |gnt_s;
    ram_addr  = sel_req_s.addr[ADDR_W+1:2];
    ram_wdata = sel_req_s.wdata;
    if (ram_en) begin
      ram_we = wr_strobes(sel_req_s.we, sel_req_s.wstrb);
    end else begin
      ram_we = 4'b0000;
    end
  end

  // Next state: lock entry on a locked grant, exit on release or on timeout under contention
  always_comb begin
    state_s   = state_r;
    cnt_s     = lock_cnt_r;
    rr_last_s = rr_last_r;
    if (|gnt_s) begin
      rr_last_s = sel_s;
    end else begin
      rr_last_s = rr_last_r;
    end
    case (state_r)
      ST_IDLE: begin
        if ((|gnt_s) && sel_req_s.lock) begin
          state_s = sel_s ? ST_LOCK1 : ST_LOCK0;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_IDLE;
          cnt_s   = lock_cnt_r;
        end
      end
      ST_LOCK0, ST_LOCK1: begin
        if (!lock_s[owner_s]) begin
          state_s = ST_IDLE;
        end else if (at_max_s && req_s[~owner_s]) begin
          // Owner marked as last winner so the waiting master takes the next idle cycle
          state_s   = ST_IDLE;
          rr_last_s = owner_s;
        end else if (!at_max_s) begin
          cnt_s = lock_cnt_r + CNT_ONE;
        end else begin
          cnt_s = lock_cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, lock counter, round-robin pointer and outstanding-read tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      lock_cnt_r <= CNT_ZERO;
      rr_last_r  <= 1'b1;
      pend_r     <= 1'b0;
      resp_sel_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      lock_cnt_r <= cnt_s;
      rr_last_r  <= rr_last_s;
      pend_r     <= ram_en & ~sel_req_s.we;
      resp_sel_r <= sel_s;
    end
  end

  // Responses: rdata is shared, rvalid is routed by the registered selector
  always_comb begin
    rsp0_s.gnt    = gnt_s[0];
    rsp0_s.rvalid = pend_r & ~resp_sel_r & ~rst;
    rsp0_s.rdata  = ram_rdata;
    rsp1_s.gnt    = gnt_s[1];
    rsp1_s.rvalid = pend_r & resp_sel_r & ~rst;
    rsp1_s.rdata  = ram_rdata;
  end

  assign m0.rsp_pkt = rsp0_s;
  assign m1.rsp_pkt = rsp1_s;

  // Address bits outside the RAM word range are intentionally ignored
  assign unused_s = ^{m0.req_pkt.addr[31:ADDR_W+2], m0.req_pkt.addr[1:0],
                      m1.req_pkt.addr[31:ADDR_W+2], m1.req_pkt.addr[1:0],
                      sel_req_s.req};

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios followed by random
// traffic, all checked cycle by cycle against a rule-level reference model.
module tb_ram_arbiter;
  import soc_bus_pkg::*;

  localparam int AW   = 12;
  localparam int LMAX = 8;
  localparam int NW   = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  logic ram_en;
  logic [3:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  ram_arbiter_if m0_if ();
  ram_arbiter_if m1_if ();

  ram_arbiter #(.ADDR_W(AW), .LOCK_MAX(LMAX)) dut (
    .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, one-cycle read latency
  logic [31:0] ram [0:NW-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we == 4'b0000) begin
        ram_rdata <= ram[ram_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (ram_we[b]) ram[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        end
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Stimulus registers
  logic        b_rst;
  logic [1:0]  b_req, b_we, b_lock;
  logic [31:0] b_addr [2];
  logic [31:0] b_wdata [2];
  logic [3:0]  b_wstrb [2];

  // Reference model state
  int          own  = -1;
  int          age  = 0;
  int          last = 1;
  bit          pend = 1'b0;
  int          psel = 0;
  logic [31:0] exp_rd;
  bit          exp_known;
  logic [31:0] shadow [0:NW-1];
  bit          sval [0:NW-1];

  // Captured DUT outputs of the most recent step
  logic cap_g0, cap_g1, cap_en, cap_rv0, cap_rv1;
  logic [AW-1:0] cap_addr;
  logic [3:0] cap_we;
  logic [31:0] cap_rd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_m(input int m, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb, input logic lock);
    b_req[m] = req; b_we[m] = we; b_addr[m] = addr;
    b_wdata[m] = wdata; b_wstrb[m] = wstrb; b_lock[m] = lock;
  endtask

  task automatic idle_all();
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  // One clock cycle: drive, predict, compare, then advance the model
  task automatic step();
    int g;
    int w;
    logic [3:0] stb;
    rst = b_rst;
    m0_if.req_pkt = '{req: b_req[0], we: b_we[0], addr: b_addr[0], wdata: b_wdata[0], wstrb: b_wstrb[0], lock: b_lock[0]};
    m1_if.req_pkt = '{req: b_req[1], we: b_we[1], addr: b_addr[1], wdata: b_wdata[1], wstrb: b_wstrb[1], lock: b_lock[1]};
    @(negedge clk);
    g = -1;
    if (!b_rst) begin
      if (own >= 0) begin
        if (b_req[own]) g = own;
      end else if (b_req[0] && b_req[1]) g = 1 - last;
      else if (b_req[0]) g = 0;
      else if (b_req[1]) g = 1;
    end
    cap_g0 = m0_if.rsp_pkt.gnt;  cap_g1 = m1_if.rsp_pkt.gnt;  cap_en = ram_en;
    cap_rv0 = m0_if.rsp_pkt.rvalid; cap_rv1 = m1_if.rsp_pkt.rvalid;
    cap_addr = ram_addr; cap_we = ram_we; cap_rd0 = m0_if.rsp_pkt.rdata;
    chk("gnt0", 32'(cap_g0), 32'(g == 0));
    chk("gnt1", 32'(cap_g1), 32'(g == 1));
    chk("ram_en", 32'(cap_en), 32'(g >= 0));
    if (g >= 0) begin
      chk("ram_addr", 32'(cap_addr), 32'(b_addr[g][AW+1:2]));
      chk("ram_we", 32'(cap_we), 32'(b_we[g] ? b_wstrb[g] : 4'h0));
      if (b_we[g]) chk("ram_wdata", ram_wdata, b_wdata[g]);
    end else begin
      chk("ram_we_idle", 32'(cap_we), 32'h0);
    end
    chk("rvalid0", 32'(cap_rv0), 32'(!b_rst && pend && psel == 0));
    chk("rvalid1", 32'(cap_rv1), 32'(!b_rst && pend && psel == 1));
    if (!b_rst && pend && exp_known) begin
      if (psel == 0) chk("rdata0", m0_if.rsp_pkt.rdata, exp_rd);
      else           chk("rdata1", m1_if.rsp_pkt.rdata, exp_rd);
    end
    @(posedge clk);
    if (b_rst) begin
      own = -1; age = 0; last = 1; pend = 1'b0;
    end else begin
      pend = 1'b0;
      if (g >= 0) begin
        w = int'(b_addr[g][AW+1:2]);
        if (b_we[g]) begin
          stb = b_wstrb[g];
          for (int b = 0; b < 4; b++) if (stb[b]) shadow[w][b*8 +: 8] = b_wdata[g][b*8 +: 8];
          if (stb == 4'hF) sval[w] = 1'b1;
        end else begin
          pend = 1'b1; psel = g; exp_rd = shadow[w]; exp_known = sval[w];
        end
        last = g;
      end
      if (own < 0) begin
        if (g >= 0 && b_lock[g]) begin own = g; age = 0; end
      end else if (!b_lock[own]) begin
        own = -1;
      end else if (age == LMAX && b_req[1 - own]) begin
        last = own; own = -1;
      end else if (age < LMAX) begin
        age++;
      end
    end
    #1;
  endtask

  initial begin
    b_rst = 1'b1;
    // Reset with both masters requesting: nothing may be granted
    set_m(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
    set_m(1, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 1'b0);
    step(); step();
    chk("reset_en", 32'(cap_en), 32'h0);

    // Contention from reset: m0,m1,m0,m1
    b_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("cont_g0", 32'(cap_g0), 32'(i % 2 == 0));
      chk("cont_g1", 32'(cap_g1), 32'(i % 2 == 1));
    end
    idle_all(); step();
    chk("cont_last_rv1", 32'(cap_rv1), 32'h1);

    // Single master write then read
    set_m(0, 1'b1, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 1'b0);
    step();
    chk("wr_g0", 32'(cap_g0), 32'h1);
    chk("wr_addr", 32'(cap_addr), 32'h4);
    set_m(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0);
    step();
    chk("rd_g0", 32'(cap_g0), 32'h1);
    idle_all(); step();
    chk("rd_rv0", 32'(cap_rv0), 32'h1);
    chk("rd_rv1", 32'(cap_rv1), 32'h0);
    chk("rd_data", cap_rd0, 32'hDEADBEEF);

    // Lock: m1 locks, m0 waits until the release is sampled
    set_m(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    set_m(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
    step();
    chk("lock_g1", 32'(cap_g1), 32'h1);
    set_m(1, 1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
    step(); chk("lock_hold_a", 32'(cap_g0), 32'h0);
    step(); chk("lock_hold_b", 32'(cap_g0), 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    step(); chk("lock_rel_cycle", 32'(cap_g0), 32'h0);
    step(); chk("lock_after", 32'(cap_g0), 32'h1);
    idle_all(); step();

    // Lock timeout: m1 never releases, m0 keeps asking
    set_m(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    set_m(1, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("to_hold_g1", 32'(cap_g1), 32'h1);
      chk("to_hold_g0", 32'(cap_g0), 32'h0);
    end
    step();
    chk("to_take_g0", 32'(cap_g0), 32'h1);
    chk("to_take_g1", 32'(cap_g1), 32'h0);
    idle_all(); step();

    // Reset in the cycle after an accepted m0 read
    set_m(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    step();
    set_m(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    b_rst = 1'b1;
    step();
    chk("rst_rv0", 32'(cap_rv0), 32'h0);
    chk("rst_g0", 32'(cap_g0), 32'h0);
    chk("rst_g1", 32'(cap_g1), 32'h0);
    b_rst = 1'b0;
    step();
    chk("rst_tie_g0", 32'(cap_g0), 32'h1);
    idle_all(); step();

    // Address wrap and partial strobes
    set_m(0, 1'b1, 1'b1, 32'h0000_0008, 32'hAABBCCDD, 4'hF, 1'b0);
    step(); idle_all();
    set_m(1, 1'b1, 1'b1, 32'h0001_4008, 32'h11223344, 4'h3, 1'b0);
    step();
    chk("wrap_addr", 32'(cap_addr), 32'h002);
    chk("wrap_we", 32'(cap_we), 32'h3);
    idle_all();
    set_m(0, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0, 1'b0);
    step(); idle_all(); step();
    chk("wrap_data", cap_rd0, 32'hAABB3344);

    // Random traffic over a small pre-initialised window of words
    for (int i = 0; i < 16; i++) begin
      set_m(0, 1'b1, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0);
      step();
    end
    for (int i = 0; i < 400; i++) begin
      b_rst = ($urandom_range(0, 63) == 0);
      for (int m = 0; m < 2; m++) begin
        set_m(m, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
              (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'hFFFF_C003),
              $urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
      end
      step();
    end
    b_rst = 1'b0; idle_all(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
